axis2rowbuf: RTL and testbench

Next-generation AXI-Stream pixel deserialiser for the conware datapath.
- Converts a stream of DWIDTH-bit pixels into WIDTH-bit rows of cell state (1 = alive, 0 = dead).
- Double-buffered, so the stream keeps flowing while the computation core holds a row.
- Tracks rows per frame, marks the last row of a frame, and flags TLAST misalignment.
- Sits between the VDMA MM2S stream and the conware computation engine.

---
 rtl/conware_pkg.sv | 27 ++
 rtl/axis_pix_decode.sv | 23 ++
 rtl/axis2rowbuf.sv | 129 ++++++++++++
 tb/tb_axis2rowbuf.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conware_pkg.sv
// Shared definitions for the conware stream datapath: default geometry, width helper,
// slot-select constants and the row-close classification.
package conware_pkg;

  localparam int unsigned DEF_DWIDTH = 32;
  localparam int unsigned DEF_WIDTH  = 8;
  localparam int unsigned DEF_HEIGHT = 8;

  localparam logic SLOT0 = 1'b0;
  localparam logic SLOT1 = 1'b1;

  // Why a row closed; anything other than CloseNormal is a TLAST framing error.
  typedef enum logic [1:0] {
    CloseNormal,
    CloseShortRow,
    CloseShortFrame,
    CloseLongFrame
  } close_kind_e;

  // Counter width that never collapses to zero bits.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/axis_pix_decode.sv
// Combinational alive-colour decode of one pixel; shared with the buffer2axis encoder.
// Optional masked compare is enabled by defining CONWARE_COLOR_MASK_EN.
module axis_pix_decode
  import conware_pkg::*;
#(
  parameter int unsigned DWIDTH = DEF_DWIDTH
) (
  input  logic [DWIDTH-1:0] i_tdata,
  input  logic [DWIDTH-1:0] i_alive_color,
`ifdef CONWARE_COLOR_MASK_EN
  input  logic [DWIDTH-1:0] i_color_mask,
`endif
  output logic              o_alive
);

`ifdef CONWARE_COLOR_MASK_EN
  // Only bits selected by the mask take part; an all-zero mask matches every pixel.
  assign o_alive = ((i_tdata & i_color_mask) == (i_alive_color & i_color_mask));
`else
  assign o_alive = (i_tdata == i_alive_color);
`endif

endmodule

// File: rtl/axis2rowbuf.sv
// AXI-Stream pixel deserialiser: packs decoded pixels into double-buffered rows of cells.
// Defining CONWARE_COLOR_MASK_EN adds the color_mask port and a masked colour compare.
module axis2rowbuf
  import conware_pkg::*;
#(
  parameter int unsigned DWIDTH = DEF_DWIDTH,
  parameter int unsigned WIDTH  = DEF_WIDTH,
  parameter int unsigned HEIGHT = DEF_HEIGHT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DWIDTH-1:0] alive_color,
`ifdef CONWARE_COLOR_MASK_EN
  input  logic [DWIDTH-1:0] color_mask,
`endif
  input  logic [DWIDTH-1:0] S_AXIS_TDATA,
  input  logic              S_AXIS_TVALID,
  input  logic              S_AXIS_TLAST,
  output logic              S_AXIS_TREADY,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              frame_err
);

  localparam int unsigned CW = clog2(WIDTH);
  localparam int unsigned RW = clog2(HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

  logic [WIDTH-1:0] r_slot [2];
  logic [1:0]       r_full;
  logic [1:0]       r_tag;
  logic             r_wr_sel;
  logic             r_rd_sel;
  logic [CW-1:0]    r_col;
  logic [RW-1:0]    r_row;
  logic             r_frame_err;

  logic             w_alive;
  logic             w_accept;
  logic             w_col_end;
  logic             w_row_end;
  logic             w_close;
  logic             w_tag;
  logic             w_xfer;
  logic [WIDTH-1:0] w_row_next;
  close_kind_e      w_kind;

  axis_pix_decode #(
    .DWIDTH (DWIDTH)
  ) u_decode (
    .i_tdata       (S_AXIS_TDATA),
    .i_alive_color (alive_color),
`ifdef CONWARE_COLOR_MASK_EN
    .i_color_mask  (color_mask),
`endif
    .o_alive       (w_alive)
  );

  assign S_AXIS_TREADY = !r_full[r_wr_sel] && !rst;
  assign w_accept      = S_AXIS_TVALID && S_AXIS_TREADY;
  assign w_col_end     = (r_col == COL_LAST);
  assign w_row_end     = (r_row == ROW_LAST);
  assign w_close       = w_accept && (w_col_end || S_AXIS_TLAST);
  assign w_tag         = S_AXIS_TLAST || w_row_end;

  assign out_valid = r_full[r_rd_sel];
  assign out_data  = r_slot[r_rd_sel];
  assign out_last  = r_tag[r_rd_sel];
  assign frame_err = r_frame_err;
  assign w_xfer    = out_valid && out_ready;

  // Column 0 starts from a cleared row so a short row never carries stale cells.
  always_comb begin
    w_row_next        = (r_col == '0) ? '0 : r_slot[r_wr_sel];
    w_row_next[r_col] = w_alive;
  end

  always_comb begin
    w_kind = CloseNormal;
    if (w_close) begin
      if (S_AXIS_TLAST && !w_col_end) begin
        w_kind = CloseShortRow;
      end else if (S_AXIS_TLAST && !w_row_end) begin
        w_kind = CloseShortFrame;
      end else if (!S_AXIS_TLAST && w_row_end) begin
        w_kind = CloseLongFrame;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_slot[0]   <= '0;
      r_slot[1]   <= '0;
      r_full      <= '0;
      r_tag       <= '0;
      r_wr_sel    <= SLOT0;
      r_rd_sel    <= SLOT0;
      r_col       <= '0;
      r_row       <= '0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= (w_kind != CloseNormal);

      // Drain and fill never target the same slot: TREADY is low while the write slot is full.
      if (w_xfer) begin
        r_full[r_rd_sel] <= 1'b0;
        r_rd_sel         <= ~r_rd_sel;
      end

      if (w_accept) begin
        r_slot[r_wr_sel] <= w_row_next;
        if (w_close) begin
          r_full[r_wr_sel] <= 1'b1;
          r_tag[r_wr_sel]  <= w_tag;
          r_wr_sel         <= ~r_wr_sel;
          r_col            <= '0;
          r_row            <= w_tag ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_axis2rowbuf.sv
// Self-checking bench for axis2rowbuf: queue-based row model plus directed literal checks.
module tb_axis2rowbuf;

  localparam int W = 8;
  localparam int H = 8;
  localparam logic [31:0] ALIVE = 32'h00FF_FFFF;
  localparam logic [31:0] DEAD  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] alive_color;
`ifdef CONWARE_COLOR_MASK_EN
  logic [31:0] color_mask;
`endif
  logic [31:0] tdata;
  logic        tvalid;
  logic        tlast;
  logic        tready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        frame_err;

  always #5 clk = ~clk;

  axis2rowbuf #(
    .DWIDTH (32),
    .WIDTH  (W),
    .HEIGHT (H)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .alive_color   (alive_color),
`ifdef CONWARE_COLOR_MASK_EN
    .color_mask    (color_mask),
`endif
    .S_AXIS_TDATA  (tdata),
    .S_AXIS_TVALID (tvalid),
    .S_AXIS_TLAST  (tlast),
    .S_AXIS_TREADY (tready),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_last      (out_last),
    .frame_err     (frame_err)
  );

  typedef struct {
    logic [7:0] d;
    logic       l;
  } row_t;

  int   checks = 0;
  int   errors = 0;
  int   err_pulses = 0;
  bit   chk_en = 0;

  // Model: rows closed but not yet consumed, in order; at most two can be held.
  row_t       m_q[$];
  row_t       log_q[$];
  int         m_col = 0;
  int         m_row = 0;
  logic [7:0] m_cur = '0;
  logic       m_err = 1'b0;

  function automatic logic model_alive(input logic [31:0] d);
`ifdef CONWARE_COLOR_MASK_EN
    return (d & color_mask) == (alive_color & color_mask);
`else
    return d == alive_color;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    bit   acc;
    bit   tag;
    row_t r;
    if (rst) begin
      m_q.delete();
      m_col = 0;
      m_row = 0;
      m_err = 1'b0;
    end else begin
      acc   = tvalid && (m_q.size() < 2);
      m_err = 1'b0;
      if (m_q.size() > 0 && out_ready) void'(m_q.pop_front());
      if (acc) begin
        if (m_col == 0) m_cur = '0;
        m_cur[m_col] = model_alive(tdata);
        if (m_col == W - 1 || tlast) begin
          tag   = tlast || (m_row == H - 1);
          m_err = (tlast && m_col != W - 1) || (tlast && m_row != H - 1) ||
                  (!tlast && m_row == H - 1);
          r.d   = m_cur;
          r.l   = tag;
          m_q.push_back(r);
          m_col = 0;
          m_row = tag ? 0 : m_row + 1;
        end else begin
          m_col++;
        end
      end
    end
  end

  always @(negedge clk) begin
    row_t r;
    if (chk_en) begin
      chk("tready", tready, !rst && (m_q.size() < 2));
      chk("out_valid", out_valid, m_q.size() > 0);
      if (m_q.size() > 0) begin
        chk("out_data", out_data, m_q[0].d);
        chk("out_last", out_last, m_q[0].l);
      end
      chk("frame_err", frame_err, m_err);
      if (frame_err === 1'b1) err_pulses++;
      if (out_valid === 1'b1 && out_ready && !rst) begin
        r.d = out_data;
        r.l = out_last;
        log_q.push_back(r);
      end
    end
  end

  task automatic send(input logic [31:0] d, input logic l);
    bit acc;
    int n;
    tvalid = 1'b1;
    tdata  = d;
    tlast  = l;
    acc    = 0;
    n      = 0;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = tready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: beat not accepted within %0d cycles", n);
    end
  endtask

  task automatic send_row(input logic [7:0] pat, input logic last_on_end);
    for (int i = 0; i < W; i++) send(pat[i] ? ALIVE : DEAD, last_on_end && (i == W - 1));
  endtask

  task automatic idle(input int n);
    tvalid = 1'b0;
    tlast  = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    tvalid = 1'b0;
    tlast  = 1'b0;
    rst    = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic chk_row(input string name, input int idx, input logic [7:0] d, input logic l);
    if (idx < log_q.size()) begin
      chk({name, "_data"}, log_q[idx].d, d);
      chk({name, "_last"}, log_q[idx].l, l);
    end else begin
      checks++;
      errors++;
      $display("FAIL %s: row %0d never emitted, only %0d rows seen", name, idx, log_q.size());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [7:0] pats [8];
  int n0;
  int e0;

  initial begin
    rst         = 1'b1;
    tvalid      = 1'b0;
    tlast       = 1'b0;
    tdata       = '0;
    out_ready   = 1'b1;
    alive_color = ALIVE;
`ifdef CONWARE_COLOR_MASK_EN
    color_mask  = 32'hFFFF_FFFF;
`endif
    for (int r = 0; r < 8; r++) pats[r] = 8'((r * 37 + 11) ^ (r << 4));

    @(posedge clk);
    #1;
    chk_en = 1;
    chk("rst_tready", tready, 1'b0);
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_data", out_data, 8'h00);
    chk("rst_err", frame_err, 1'b0);
    rst = 1'b0;

    // Single row with the consumer always ready.
    n0 = log_q.size();
    e0 = err_pulses;
    send_row(8'b1000_1101, 1'b0);
    idle(3);
    chk("t1_rows", log_q.size() - n0, 1);
    chk_row("t1_row", n0, 8'h8D, 1'b0);
    chk("t1_err", err_pulses - e0, 0);

    // Back-pressure: two rows buffered, third waits until the consumer releases.
    do_reset();
    out_ready = 1'b0;
    n0 = log_q.size();
    send_row(8'hA5, 1'b0);
    send_row(8'h3C, 1'b0);
    idle(3);
    chk("t2_tready_low", tready, 1'b0);
    chk("t2_held_data", out_data, 8'hA5);
    fork
      send_row(8'hF0, 1'b0);
      begin
        repeat (6) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    idle(4);
    chk("t2_rows", log_q.size() - n0, 3);
    chk_row("t2_r0", n0, 8'hA5, 1'b0);
    chk_row("t2_r1", n0 + 1, 8'h3C, 1'b0);
    chk_row("t2_r2", n0 + 2, 8'hF0, 1'b0);
    chk("t2_tready_back", tready, 1'b1);

    // Full well-formed frame.
    do_reset();
    n0 = log_q.size();
    e0 = err_pulses;
    for (int r = 0; r < H; r++) send_row(pats[r], r == H - 1);
    idle(3);
    chk("t3_rows", log_q.size() - n0, H);
    for (int r = 0; r < H; r++) chk_row($sformatf("t3_r%0d", r), n0 + r, pats[r], r == H - 1);
    chk("t3_err", err_pulses - e0, 0);

    // Short row: TLAST on the third pixel, then a fresh row 0.
    n0 = log_q.size();
    e0 = err_pulses;
    send(ALIVE, 1'b0);
    send(DEAD, 1'b0);
    send(ALIVE, 1'b1);
    send_row(8'h5A, 1'b0);
    idle(3);
    chk_row("t4_short", n0, 8'h05, 1'b1);
    chk_row("t4_next", n0 + 1, 8'h5A, 1'b0);
    chk("t4_err", err_pulses - e0, 1);

    // Short frame: TLAST at the end of row 1.
    n0 = log_q.size();
    e0 = err_pulses;
    send_row(8'h0F, 1'b1);
    idle(3);
    chk_row("t4b_shortframe", n0, 8'h0F, 1'b1);
    chk("t4b_err", err_pulses - e0, 1);

    // Long frame: no TLAST on the final row.
    do_reset();
    n0 = log_q.size();
    e0 = err_pulses;
    for (int r = 0; r < H; r++) send_row(pats[r], 1'b0);
    idle(3);
    chk_row("t4c_last_row", n0 + H - 1, pats[H-1], 1'b1);
    chk_row("t4c_row6", n0 + H - 2, pats[H-2], 1'b0);
    chk("t4c_err", err_pulses - e0, 1);

    // Mid-row reset discards the partial row.
    n0 = log_q.size();
    for (int i = 0; i < 5; i++) send(ALIVE, 1'b0);
    tvalid = 1'b0;
    rst    = 1'b1;
    @(negedge clk);
    chk("t5_tready_rst", tready, 1'b0);
    @(posedge clk);
    #1;
    chk("t5_valid_rst", out_valid, 1'b0);
    rst = 1'b0;
    send_row(8'hC3, 1'b0);
    idle(3);
    chk("t5_rows", log_q.size() - n0, 1);
    chk_row("t5_row", n0, 8'hC3, 1'b0);

    // Colour decode, masked or exact depending on the build.
    do_reset();
`ifdef CONWARE_COLOR_MASK_EN
    color_mask = 32'h00FF_FFFF;
`endif
    n0 = log_q.size();
    send(32'hAAFF_FFFF, 1'b0);
    send(DEAD, 1'b0);
    send(ALIVE, 1'b0);
    send(32'hAAFF_FFFF, 1'b0);
    for (int i = 0; i < 4; i++) send(DEAD, 1'b0);
    idle(3);
`ifdef CONWARE_COLOR_MASK_EN
    chk_row("t6_mask", n0, 8'h0D, 1'b0);
`else
    chk_row("t6_exact", n0, 8'h04, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
